// File: rtl/score_keeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper_pkg
//  Purpose  : Shared types and helpers for the score keeper and HUD logic.
//  Revision : 1.0 - initial release
// ============================================================================

package score_keeper_pkg;

    localparam int SCORE_DIGITS = 6;
    localparam int QUAD_W       = 11;

    typedef logic [SCORE_DIGITS-1:0][3:0] bcd_score_t;

    typedef enum logic [1:0] {
        SK_IDLE  = 2'd0,
        SK_ADD   = 2'd1,
        SK_BONUS = 2'd2
    } sk_state_t;

    // Quad points carry only three digits; hundreds field is 3 bits wide.
    function automatic bcd_score_t quad_to_bcd(input logic [QUAD_W-1:0] pts);
        bcd_score_t v;
        v    = '0;
        v[0] = pts[3:0];
        v[1] = pts[7:4];
        v[2] = {1'b0, pts[10:8]};
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_keeper_bcd_adder.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_adder
//  Purpose  : Combinational N-digit BCD ripple adder with per-digit carries.
//  Revision : 1.0 - initial release
// ============================================================================

module bcd_adder #(
    parameter int DIGITS = 6
) (
    input  logic [DIGITS*4-1:0] i_a,
    input  logic [DIGITS*4-1:0] i_b,
    input  logic                i_cin,
    output logic [DIGITS*4-1:0] o_sum,
    output logic [DIGITS-1:0]   o_carry
);

    always_comb begin
        logic       w_c;
        logic [4:0] w_t;
        o_sum   = '0;
        o_carry = '0;
        w_c     = i_cin;
        for (int d = 0; d < DIGITS; d++) begin
            w_t = {1'b0, i_a[d*4 +: 4]} + {1'b0, i_b[d*4 +: 4]} + {4'b0, w_c};
            if (w_t > 5'd9) begin
                w_t = w_t + 5'd6;
                w_c = 1'b1;
            end else begin
                w_c = 1'b0;
            end
            o_sum[d*4 +: 4] = w_t[3:0];
            o_carry[d]      = w_c;
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : score_keeper
//  Purpose  : Per-frame BCD score accumulation, bonus ships, lives, high score.
//  Revision : 1.0 - initial release
// ============================================================================

module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int NUM_QUADS   = 2,
    parameter int INIT_LIVES  = 3,
    parameter int MAX_LIVES   = 9,
    parameter int BONUS_DIGIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        vsync,
    input  logic                        game_begin,
    input  logic                        ship_hit,
    input  logic [NUM_QUADS*QUAD_W-1:0] ast_points,
    output logic [23:0]                 score_bcd,
    output logic [23:0]                 high_score_bcd,
    output logic [3:0]                  lives,
    output logic                        game_active,
    output logic                        extra_life,
    output logic                        game_over,
    output logic                        overrun
);

    localparam int             c_idx_w      = $clog2(NUM_QUADS) + 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_QUADS - 1);
    localparam logic [3:0]     c_init_lives = 4'(INIT_LIVES);
    localparam logic [3:0]     c_max_lives  = 4'(MAX_LIVES);

    sk_state_t              r_state;
    sk_state_t              w_state_nxt;
    logic                   r_cap_en;
    logic [QUAD_W-1:0]      r_cap [NUM_QUADS];
    logic [c_idx_w-1:0]     r_idx;
    bcd_score_t             r_score;
    bcd_score_t             r_high;
    logic [3:0]             r_lives;
    logic                   r_active;
    logic                   r_bonus;
    logic                   r_dead;
    logic                   r_overrun;

    logic [QUAD_W-1:0]      w_quad;
    bcd_score_t             w_addend;
    bcd_score_t             w_sum;
    logic [SCORE_DIGITS-1:0] w_carry;
    logic                   w_carry_in_bonus;
    logic                   w_bonus_hit;
    logic                   w_capture;
    logic                   w_hit;
    logic                   w_grant;
    logic                   w_end_game;

    // Capture is refused once the last ship is gone, even before game_active drops.
    assign w_capture  = r_cap_en && r_active && !r_dead;
    assign w_hit      = ship_hit && r_active && !r_dead && (r_lives != 4'd0);
    assign w_grant    = (r_state == SK_BONUS) && r_bonus && !r_dead && (r_lives < c_max_lives);
    assign w_end_game = r_dead && (r_state == SK_IDLE);

    always_comb begin
        w_quad = '0;
        for (int i = 0; i < NUM_QUADS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_quad = r_cap[i];
            end
        end
    end

    assign w_addend = quad_to_bcd(w_quad);

    bcd_adder #(
        .DIGITS (SCORE_DIGITS)
    ) u_adder (
        .i_a     (r_score),
        .i_b     (w_addend),
        .i_cin   (1'b0),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    generate
        if (BONUS_DIGIT > 0) begin : g_bonus_carry
            assign w_carry_in_bonus = w_carry[BONUS_DIGIT-1];
        end else begin : g_bonus_nocarry
            assign w_carry_in_bonus = 1'b0;
        end
    endgenerate

    always_comb begin
        w_bonus_hit = w_carry_in_bonus;
        for (int d = BONUS_DIGIT; d < SCORE_DIGITS; d++) begin
            if (w_sum[d] != r_score[d]) begin
                w_bonus_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SK_IDLE:  if (w_capture) w_state_nxt = SK_ADD;
            SK_ADD:   if (r_idx == c_last_idx) w_state_nxt = SK_BONUS;
            SK_BONUS: w_state_nxt = SK_IDLE;
            default:  w_state_nxt = SK_IDLE;
        endcase
        if (game_begin) begin
            w_state_nxt = SK_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SK_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_en  <= 1'b0;
            r_idx     <= '0;
            r_score   <= '0;
            r_high    <= '0;
            r_lives   <= 4'd0;
            r_active  <= 1'b0;
            r_bonus   <= 1'b0;
            r_dead    <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NUM_QUADS; i++) begin
                r_cap[i] <= '0;
            end
        end else begin
            r_cap_en <= vsync;
            if (game_begin) begin
                r_idx    <= '0;
                r_score  <= '0;
                r_lives  <= c_init_lives;
                r_active <= 1'b1;
                r_bonus  <= 1'b0;
                r_dead   <= 1'b0;
                for (int i = 0; i < NUM_QUADS; i++) begin
                    r_cap[i] <= '0;
                end
            end else begin
                if (w_capture) begin
                    if (r_state == SK_IDLE) begin
                        r_idx <= '0;
                        for (int i = 0; i < NUM_QUADS; i++) begin
                            r_cap[i] <= ast_points[i*QUAD_W +: QUAD_W];
                        end
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end

                if (r_state == SK_ADD) begin
                    r_score <= w_sum;
                    r_idx   <= r_idx + c_idx_w'(1);
                    if (w_bonus_hit) begin
                        r_bonus <= 1'b1;
                    end
                end else if (r_state == SK_BONUS) begin
                    r_bonus <= 1'b0;
                end

                // A grant and a hit in the same cycle cancel out.
                if (w_grant && !w_hit) begin
                    r_lives <= r_lives + 4'd1;
                end else if (w_hit && !w_grant) begin
                    r_lives <= r_lives - 4'd1;
                    if (r_lives == 4'd1) begin
                        r_dead <= 1'b1;
                    end
                end

                if (w_end_game) begin
                    r_active <= 1'b0;
                    r_dead   <= 1'b0;
                    if (r_score > r_high) begin
                        r_high <= r_score;
                    end
                end
            end
        end
    end

    assign score_bcd      = r_score;
    assign high_score_bcd = r_high;
    assign lives          = r_lives;
    assign game_active    = r_active;
    assign extra_life     = w_grant && !game_begin;
    assign game_over      = w_end_game && !game_begin;
    assign overrun        = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_keeper
//  Purpose  : Self-checking scoreboard bench for score_keeper.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_score_keeper;

    localparam int c_nq = 2;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        game_begin;
    logic        ship_hit;
    logic [21:0] ast_points;
    logic [23:0] score_bcd;
    logic [23:0] high_score_bcd;
    logic [3:0]  lives;
    logic        game_active;
    logic        extra_life;
    logic        game_over;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int n_extra = 0;
    int n_over  = 0;
    int exp_extra = 0;
    int exp_over  = 0;

    int score_m  = 0;
    int high_m   = 0;
    int lives_m  = 0;
    bit active_m = 0;
    logic [23:0] exp_q [$];

    score_keeper #(
        .NUM_QUADS   (c_nq),
        .INIT_LIVES  (3),
        .MAX_LIVES   (9),
        .BONUS_DIGIT (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .vsync          (vsync),
        .game_begin     (game_begin),
        .ship_hit       (ship_hit),
        .ast_points     (ast_points),
        .score_bcd      (score_bcd),
        .high_score_bcd (high_score_bcd),
        .lives          (lives),
        .game_active    (game_active),
        .extra_life     (extra_life),
        .game_over      (game_over),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (extra_life) n_extra <= n_extra + 1;
        if (game_over)  n_over  <= n_over + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        r = '0;
        for (int d = 0; d < 6; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [10:0] enc(input int v);
        logic [2:0] h;
        logic [3:0] t;
        h = 3'(v / 100);
        t = 4'((v / 10) % 10);
        return {h, t, 4'h0};
    endfunction

    // Model the frame, queue expected score, then compare at NUM_QUADS+2 cycles.
    task automatic frame(input int q0, input int q1);
        int old;
        old = score_m;
        if (active_m) begin
            score_m = (score_m + q0 + q1) % 1000000;
            if ((old / 10000) != (score_m / 10000) && lives_m < 9) begin
                lives_m++;
                exp_extra++;
            end
        end
        exp_q.push_back(to_bcd(score_m));
        vsync = 1'b1;
        ast_points = {enc(q1), enc(q0)};
        tick();
        vsync = 1'b0;
        tick();
        tick();
        ast_points = '0;
        tick();
        chk("score", score_bcd, exp_q.pop_front());
        tick();
        tick();
        chk("extra_cnt", n_extra, exp_extra);
        chk("lives", lives, lives_m);
    endtask

    task automatic fill(input int target);
        int rem;
        while (target - score_m >= 1580) frame(790, 790);
        rem = target - score_m;
        if (rem > 0) frame((rem > 790) ? 790 : rem, (rem > 790) ? rem - 790 : 0);
    endtask

    task automatic kill();
        ship_hit = 1'b1;
        tick();
        ship_hit = 1'b0;
        if (active_m && lives_m > 0) begin
            lives_m--;
            if (lives_m == 0) begin
                exp_over++;
                active_m = 0;
                if (score_m > high_m) high_m = score_m;
            end
        end
        tick();
        tick();
        tick();
        chk("kill_lives", lives, lives_m);
        chk("kill_over_cnt", n_over, exp_over);
        chk("kill_active", game_active, active_m);
        chk("kill_high", high_score_bcd, to_bcd(high_m));
    endtask

    task automatic begin_game(input logic with_hit);
        game_begin = 1'b1;
        ship_hit   = with_hit;
        tick();
        game_begin = 1'b0;
        ship_hit   = 1'b0;
        score_m  = 0;
        lives_m  = 3;
        active_m = 1;
        tick();
        chk("begin_score", score_bcd, 24'h0);
        chk("begin_lives", lives, lives_m);
        chk("begin_active", game_active, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        vsync = 1'b0;
        game_begin = 1'b0;
        ship_hit = 1'b0;
        ast_points = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_score", score_bcd, 24'h0);
        chk("rst_high", high_score_bcd, 24'h0);
        chk("rst_lives", lives, 4'd0);
        chk("rst_active", game_active, 1'b0);
        chk("rst_overrun", overrun, 1'b0);

        // Game A: basic two-quad frame, then lose all ships while idle.
        begin_game(1'b0);
        frame(20, 50);
        chk("a_score70", score_bcd, 24'h000070);
        kill();
        kill();
        kill();
        chk("a_high70", high_score_bcd, 24'h000070);

        // Attract mode: points must not count.
        frame(300, 400);
        chk("attract_score", score_bcd, 24'h000070);

        // Game B: lower score does not replace the high score.
        begin_game(1'b0);
        frame(20, 0);
        kill();
        kill();
        kill();
        chk("b_high", high_score_bcd, 24'h000070);

        // Game C: last ship lost during ADD; frame finishes and counts for high.
        begin_game(1'b0);
        kill();
        kill();
        vsync = 1'b1;
        ast_points = {enc(400), enc(400)};
        tick();
        vsync = 1'b0;
        tick();
        ship_hit = 1'b1;
        tick();
        ship_hit = 1'b0;
        ast_points = '0;
        score_m = 800;
        lives_m = 0;
        high_m  = 800;
        active_m = 0;
        exp_over++;
        repeat (5) tick();
        chk("c_score", score_bcd, 24'h000800);
        chk("c_lives", lives, 4'd0);
        chk("c_over_cnt", n_over, exp_over);
        chk("c_high", high_score_bcd, 24'h000800);
        chk("c_active", game_active, 1'b0);

        // Game D: overrun, bonus at 10000, wrap with lives at ceiling.
        begin_game(1'b0);
        vsync = 1'b1;
        ast_points = {enc(50), enc(20)};
        tick();
        tick();
        vsync = 1'b0;
        tick();
        tick();
        ast_points = '0;
        score_m = 70;
        repeat (4) tick();
        chk("d_overrun", overrun, 1'b1);
        chk("d_score", score_bcd, 24'h000070);
        fill(9980);
        chk("d_9980", score_bcd, 24'h009980);
        chk("d_lives3", lives, 4'd3);
        frame(20, 0);
        chk("d_10000", score_bcd, 24'h010000);
        chk("d_lives4", lives, 4'd4);
        fill(999990);
        chk("d_lives_max", lives, 4'd9);
        exp_q.push_back(24'h000010);
        frame(20, 0);
        chk("d_wrap", score_bcd, exp_q.pop_front());
        chk("d_wrap_lives", lives, 4'd9);

        // game_begin beats a coincident ship_hit; high and overrun persist.
        begin_game(1'b1);
        chk("e_lives", lives, 4'd3);
        chk("e_overrun", overrun, 1'b1);
        chk("e_high", high_score_bcd, 24'h000800);
        chk("e_over_cnt", n_over, exp_over);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
